// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface datamem_arbiter_if;
  logic        freeze;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  freeze, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output freeze, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data RAM: requester 0 has priority
// until requester 1 has been denied MAXWAIT consecutive cycles; reads return two cycles after grant.
module datamem_arbiter #(
  parameter int unsigned MAXWAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  datamem_arbiter_if.slave  bus
);
  localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

  logic [3:0]  waitcnt_r;
  logic [3:0]  waitcnt_nxt_s;
  logic        gnt0_s;
  logic        gnt1_s;
  logic        mem_en_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic        rd_pend0_r;
  logic        rd_pend1_r;
  logic        rvalid0_r;
  logic        rvalid1_r;

  // Grant selection; reset gates the combinational grants so they read 0 during reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset || bus.freeze) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.req1 && (waitcnt_r >= MAXWAIT_C)) begin
      gnt1_s = 1'b1;
    end else if (bus.req0) begin
      gnt0_s = 1'b1;
    end else if (bus.req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Starvation counter next value: holds while frozen, saturates at 15.
  always_comb begin
    waitcnt_nxt_s = waitcnt_r;
    if (bus.freeze) begin
      waitcnt_nxt_s = waitcnt_r;
    end else if (gnt1_s || !bus.req1) begin
      waitcnt_nxt_s = 4'd0;
    end else if (waitcnt_r != 4'd15) begin
      waitcnt_nxt_s = waitcnt_r + 4'd1;
    end else begin
      waitcnt_nxt_s = waitcnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitcnt_r <= 4'd0;
    end else begin
      waitcnt_r <= waitcnt_nxt_s;
    end
  end

  // Registered memory strobes; a no-grant cycle drives an all-zero command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 16'h0000;
    end else if (gnt0_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= bus.we0;
      mem_addr_r  <= bus.addr0;
      mem_wdata_r <= bus.wdata0;
    end else if (gnt1_s) begin
      mem_en_r    <= 1'b1;
      mem_we_r    <= bus.we1;
      mem_addr_r  <= bus.addr1;
      mem_wdata_r <= bus.wdata1;
    end else begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 16'h0000;
    end
  end

  // Read-return pipeline: one stage tracks the RAM access, the next marks data valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend0_r <= 1'b0;
      rd_pend1_r <= 1'b0;
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
    end else begin
      rd_pend0_r <= gnt0_s && !bus.we0;
      rd_pend1_r <= gnt1_s && !bus.we1;
      rvalid0_r  <= rd_pend0_r;
      rvalid1_r  <= rd_pend1_r;
    end
  end

  assign bus.gnt0      = gnt0_s;
  assign bus.gnt1      = gnt1_s;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rvalid0   = rvalid0_r;
  assign bus.rvalid1   = rvalid1_r;
  // RAM output is only valid in the return cycle, so the data path bypasses a register.
  assign bus.rdata0    = rvalid0_r ? bus.mem_rdata : 16'h0000;
  assign bus.rdata1    = rvalid1_r ? bus.mem_rdata : 16'h0000;
endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: a grant/issue-order model with a memory image checks
// every cycle, and hand-computed per-cycle expectations pin the model.
module tb_datamem_arbiter;
  localparam int MAXWAIT = 4;

  typedef struct {
    bit          v;
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
  } lit_t;

  logic clk = 1'b0;
  logic reset;
  datamem_arbiter_if bus ();

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rst_pulses = 0;
  lit_t lits[$];
  logic [15:0] ram [0:255];
  logic [15:0] mmem [0:255];

  datamem_arbiter #(.MAXWAIT(MAXWAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  function automatic logic [15:0] sigval(input int s);
    case (s)
      0:       return {15'h0, bus.gnt0};
      1:       return {15'h0, bus.gnt1};
      2:       return {15'h0, bus.mem_en};
      3:       return {15'h0, bus.mem_we};
      4:       return bus.mem_addr;
      5:       return {15'h0, bus.rvalid0};
      6:       return bus.rdata0;
      7:       return {15'h0, bus.rvalid1};
      8:       return bus.rdata1;
      9:       return bus.mem_wdata;
      default: return {12'h0, dut.waitcnt_r};
    endcase
  endfunction

  function automatic string signame(input int s);
    case (s)
      0:       return "gnt0";
      1:       return "gnt1";
      2:       return "mem_en";
      3:       return "mem_we";
      4:       return "mem_addr";
      5:       return "rvalid0";
      6:       return "rdata0";
      7:       return "rvalid1";
      8:       return "rdata1";
      9:       return "mem_wdata";
      default: return "waitcnt";
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Synchronous single-port RAM driven by the DUT's memory strobes.
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_val(8'(i));
    bus.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] = bus.mem_wdata;
        else            bus.mem_rdata = ram[bus.mem_addr[7:0]];
      end
    end
  end

  // Compare process: model of grant priority, issue-order memory and fixed return latency.
  initial begin
    acc_t h1, h2, nw;
    int   m_wait;
    int   seen;
    int   g;
    bit   rv0, rv1;
    for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
    h1 = '{default: '0};
    h2 = '{default: '0};
    m_wait = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_gnt0", 16'(bus.gnt0), 16'h0);
        chk("rst_gnt1", 16'(bus.gnt1), 16'h0);
        chk("rst_mem_en", 16'(bus.mem_en), 16'h0);
        chk("rst_mem_we", 16'(bus.mem_we), 16'h0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
        chk("rst_rvalid0", 16'(bus.rvalid0), 16'h0);
        chk("rst_rvalid1", 16'(bus.rvalid1), 16'h0);
        chk("rst_rdata0", bus.rdata0, 16'h0);
        chk("rst_rdata1", bus.rdata1, 16'h0);
        chk("rst_waitcnt", 16'(dut.waitcnt_r), 16'h0);
        h1 = '{default: '0};
        h2 = '{default: '0};
        m_wait = 0;
        seen = rst_pulses;
      end else begin
        if (seen != rst_pulses) begin
          h1 = '{default: '0};
          h2 = '{default: '0};
          m_wait = 0;
          seen = rst_pulses;
        end
        if (bus.freeze)                           g = 0;
        else if (bus.req1 && m_wait >= MAXWAIT)   g = 2;
        else if (bus.req0)                        g = 1;
        else if (bus.req1)                        g = 2;
        else                                      g = 0;
        chk("gnt0", 16'(bus.gnt0), 16'(g == 1));
        chk("gnt1", 16'(bus.gnt1), 16'(g == 2));
        chk("waitcnt", 16'(dut.waitcnt_r), 16'(m_wait));
        chk("mem_en", 16'(bus.mem_en), 16'(h1.v));
        chk("mem_we", 16'(bus.mem_we), 16'(h1.v && h1.we));
        chk("mem_addr", bus.mem_addr, h1.v ? h1.addr : 16'h0);
        chk("mem_wdata", bus.mem_wdata, h1.v ? h1.wdata : 16'h0);
        rv0 = h2.v && !h2.we && (h2.port == 1'b0);
        rv1 = h2.v && !h2.we && (h2.port == 1'b1);
        chk("rvalid0", 16'(bus.rvalid0), 16'(rv0));
        chk("rvalid1", 16'(bus.rvalid1), 16'(rv1));
        chk("rdata0", bus.rdata0, rv0 ? h2.data : 16'h0);
        chk("rdata1", bus.rdata1, rv1 ? h2.data : 16'h0);
        if (!bus.freeze) begin
          if (bus.req1 && g != 2) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
          else                    m_wait = 0;
        end
        nw = '{default: '0};
        if (g != 0) begin
          nw.v     = 1'b1;
          nw.port  = (g == 2);
          nw.we    = (g == 2) ? bus.we1 : bus.we0;
          nw.addr  = (g == 2) ? bus.addr1 : bus.addr0;
          nw.wdata = (g == 2) ? bus.wdata1 : bus.wdata0;
          if (nw.we) mmem[nw.addr[7:0]] = nw.wdata;
          else       nw.data = mmem[nw.addr[7:0]];
        end
        h2 = h1;
        h1 = nw;
      end
      foreach (lits[i]) begin
        if (lits[i].cyc == cyc) chk({"lit_", signame(lits[i].sig)}, sigval(lits[i].sig), lits[i].val);
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.freeze = 1'b0;
    bus.req0 = 1'b0;  bus.we0 = 1'b0;  bus.addr0 = 16'h0;  bus.wdata0 = 16'h0;
    bus.req1 = 1'b0;  bus.we1 = 1'b0;  bus.addr1 = 16'h0;  bus.wdata1 = 16'h0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) step();
  endtask

  task automatic lit(input int c, input int s, input logic [15:0] v);
    lit_t l;
    l.cyc = c;
    l.sig = s;
    l.val = v;
    lits.push_back(l);
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Single read of preloaded word.
    c0 = cyc;
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    lit(c0, 0, 16'h1); lit(c0 + 1, 2, 16'h1); lit(c0 + 1, 4, 16'h0010);
    lit(c0 + 2, 5, 16'h1); lit(c0 + 2, 6, 16'hBEEF);
    step();
    idle(4);

    // Both requesters held high: starvation guard hands every fifth slot to requester 1.
    c0 = cyc;
    bus.req0 = 1'b1; bus.addr0 = 16'h0030;
    bus.req1 = 1'b1; bus.addr1 = 16'h0020;
    for (int k = 0; k < 10; k++) begin
      lit(c0 + k, 0, (k == 4 || k == 9) ? 16'h0 : 16'h1);
      lit(c0 + k, 1, (k == 4 || k == 9) ? 16'h1 : 16'h0);
    end
    repeat (10) step();
    idle(4);

    // Write then read of the same address, no forwarding needed.
    c0 = cyc;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0005; bus.wdata1 = 16'h1234;
    lit(c0 + 1, 3, 16'h1); lit(c0 + 1, 9, 16'h1234); lit(c0 + 2, 3, 16'h0);
    lit(c0 + 2, 2, 16'h1); lit(c0 + 3, 7, 16'h1); lit(c0 + 3, 8, 16'h1234);
    step();
    bus.we1 = 1'b0; bus.wdata1 = 16'h0;
    step();
    idle(4);

    // Freeze with a read in flight and a request pending.
    c0 = cyc;
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    lit(c0, 0, 16'h1); lit(c0 + 1, 0, 16'h0); lit(c0 + 2, 0, 16'h0); lit(c0 + 3, 0, 16'h0);
    lit(c0 + 2, 5, 16'h1); lit(c0 + 2, 6, 16'hBEEF); lit(c0 + 4, 0, 16'h1); lit(c0 + 6, 5, 16'h1);
    step();
    bus.freeze = 1'b1;
    repeat (3) step();
    bus.freeze = 1'b0;
    step();
    idle(5);

    // Reset pulse right after a read is granted drops it.
    c0 = cyc;
    bus.req0 = 1'b1; bus.addr0 = 16'h0010;
    lit(c0, 0, 16'h1);
    for (int k = 1; k <= 3; k++) begin
      lit(c0 + k, 2, 16'h0);
      lit(c0 + k, 5, 16'h0);
    end
    @(posedge clk);
    #1;
    set_idle();
    reset = 1'b1;
    rst_pulses++;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    idle(4);

    // Idle period.
    c0 = cyc;
    lit(c0 + 9, 2, 16'h0); lit(c0 + 9, 0, 16'h0); lit(c0 + 9, 1, 16'h0);
    lit(c0 + 9, 5, 16'h0); lit(c0 + 9, 7, 16'h0); lit(c0 + 9, 10, 16'h0);
    idle(10);

    // Freeze holds the wait count; withdrawal clears it.
    c0 = cyc;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0040; bus.wdata0 = 16'hA5A5;
    bus.req1 = 1'b1; bus.addr1 = 16'h0020;
    lit(c0 + 1, 9, 16'hA5A5); lit(c0 + 2, 0, 16'h0); lit(c0 + 3, 10, 16'h2);
    lit(c0 + 6, 1, 16'h1); lit(c0 + 8, 0, 16'h1);
    repeat (2) step();
    bus.freeze = 1'b1;
    repeat (2) step();
    bus.freeze = 1'b0;
    repeat (3) step();
    bus.req1 = 1'b0;
    step();
    bus.req1 = 1'b1;
    step();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    lit(cyc, 1, 16'h1);
    step();
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 Parameter MAXWAIT, default 4, SHALL set the number of consecutive denied cycles after which requester 1 takes priority over requester 0 (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 freeze  input  1  SHALL suppress new grants while high (driven from processor halt).
REQ-005 req0, req1  input  1 each  SHALL be request valid, requester 0 = pipeline load/store stage, requester 1 = host/debug port.
REQ-006 we0, we1  input  1 each  SHALL select write (1) or read (0).
REQ-007 addr0, addr1  input  16 each  SHALL be the word address.
REQ-008 wdata0, wdata1  input  16 each  SHALL be the write data.
REQ-009 gnt0, gnt1  output  1 each  SHALL indicate that the request is accepted this cycle (combinational).
REQ-010 rvalid0, rvalid1  output  1 each  SHALL pulse when read data is returned.
REQ-011 rdata0, rdata1  output  16 each  SHALL carry the read data.
REQ-012 mem_en, mem_we  output  1 each  SHALL be the registered strobes to the single-port data memory.
REQ-013 mem_addr, mem_wdata  output  16 each  SHALL be the registered memory address and write data.
REQ-014 mem_rdata  input  16  SHALL be synchronous RAM output, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-016 Grant priority when freeze=0 SHALL be, in order:
- req1 && waitcnt>=MAXWAIT -> gnt1
- else req0 -> gnt0
- else req1 -> gnt1
- else no grant.
REQ-017 freeze=1 SHALL force gnt0=gnt1=0 in that cycle; waitcnt SHALL hold its value.
REQ-018 waitcnt (4 bits) SHALL update on posedge clk when freeze=0:
- +1 (saturating at 15) when req1 && !gnt1
- cleared to 0 when gnt1 || !req1.
REQ-019 A request granted in cycle N SHALL drive mem_en=1, mem_we=weK, mem_addr=addrK, mem_wdata=wdataK in cycle N+1.
REQ-020 mem_en SHALL be 0 in any cycle following a no-grant cycle; mem_we, mem_addr and mem_wdata SHALL then be 0.
REQ-021 A granted read in cycle N SHALL produce rvalidK=1 for exactly cycle N+2, with rdataK=mem_rdata in that cycle.
REQ-022 rdataK SHALL be 0 whenever rvalidK=0.
REQ-023 A granted write SHALL produce no rvalid pulse.
REQ-024 Throughput SHALL be one access per cycle; back-to-back grants SHALL pipeline, and two reads in flight SHALL return in grant order.
REQ-025 Memory ordering SHALL be issue order; there SHALL be no write-to-read forwarding (read issued the cycle after a write to the same address observes the RAM's written value).
REQ-026 A requester not granted SHALL hold req, we, addr and wdata stable; the arbiter SHALL NOT latch ungranted requests.
REQ-027 freeze asserted with accesses in flight SHALL NOT cancel them; their mem strobes and rvalid pulses SHALL complete on schedule.
REQ-028 A requester whose req is deasserted before grant SHALL be treated as having withdrawn; no access SHALL be issued for it.

Reset
REQ-029 While reset=1, the following SHALL be 0 asynchronously: gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, waitcnt, and the in-flight return pipeline.
REQ-030 Accesses in flight when reset asserts SHALL be dropped: no rvalid pulse and no memory strobe after reset deasserts.
REQ-031 The first rising clk edge after reset deasserts SHALL perform normal arbitration.

Verification
REQ-032 Single read: req0=1, we0=0, addr0=0x0010, RAM[0x0010]=0xBEEF at cycle 0 -> gnt0@0; mem_en=1, mem_addr=0x0010 @1; rvalid0=1, rdata0=0xBEEF @2.
REQ-033 Starvation guard (MAXWAIT=4): req0 and req1 held high from cycle 0 -> gnt0 @0..3, gnt1 @4, gnt0 @5..8, gnt1 @9.
REQ-034 Write then read: req1 writes 0x1234 to 0x0005 at cycle 0, then req1 reads 0x0005 at cycle 1 -> mem_we=1 @1, mem_we=0 @2, rvalid1=1 with rdata1=0x1234 @3.
REQ-035 Freeze: read granted at cycle 0, freeze=1 at cycles 1..3 with req0 high -> no grants @1..3, rvalid0 @2, gnt0 @4.
REQ-036 Reset mid-read: read granted at cycle 0, reset pulsed between cycles 0 and 1 -> mem_en=0 and rvalid0=0 through cycle 3.
REQ-037 Idle: no requests for 10 cycles -> mem_en=0, waitcnt=0, all gnt/rvalid low.
